sa_pipe_ctrl: RTL and testbench

Parametrised sequencing controller for the systolic-array compute path. It accepts matrix-multiply instructions and moves each one in lock-step through three pipeline stages: feed (FF), flush (FS) and drain (DR). It drives register-file row reads and writes plus the mesh `pump`. It adds two features over the previous controller: per-instruction active row/column counts with zero injection for tiles smaller than the mesh, and a queue of finished instruction IDs. The mesh, skewers and deskewers sit outside this block and are clocked by `pump_o`.

---
 rtl/sa_pipe_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sa_pipe_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_pipe_ctrl.sv
// Systolic-array sequencing controller: steps matrix-multiply instructions through
// feed, flush and drain slots in lock-step and queues the IDs of finished instructions.
module sa_pipe_ctrl #(
    parameter int MESH_WIDTH = 4,
    parameter int N_REGS     = 8,
    parameter int ID_WIDTH   = 4,
    parameter int FIN_DEPTH  = 2,
    localparam int RW = $clog2(N_REGS),
    localparam int SW = $clog2(MESH_WIDTH),
    localparam int CW = SW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  ready_o,
    input  logic [RW-1:0]         data_reg_i,
    input  logic [RW-1:0]         acc_reg_i,
    input  logic [RW-1:0]         weight_reg_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic [CW-1:0]         rows_i,
    input  logic [CW-1:0]         cols_i,
    output logic [RW-1:0]         data_raddr_o,
    output logic [RW-1:0]         acc_raddr_o,
    output logic [RW-1:0]         weight_raddr_o,
    output logic [SW-1:0]         rd_row_o,
    output logic                  rd_req_o,
    input  logic                  rd_valid_i,
    output logic                  rd_last_o,
    output logic                  zero_inject_o,
    output logic [MESH_WIDTH-1:0] feed_col_mask_o,
    output logic [RW-1:0]         wr_addr_o,
    output logic [SW-1:0]         wr_row_o,
    output logic                  wr_en_o,
    input  logic                  wr_ready_i,
    output logic                  wr_last_o,
    output logic                  pump_o,
    output logic [ID_WIDTH-1:0]   sa_input_id_o,
    output logic [ID_WIDTH-1:0]   sa_output_id_o,
    output logic                  finished_o,
    output logic [ID_WIDTH-1:0]   finished_id_o,
    input  logic                  finished_ack_i
);
    localparam int PW = (FIN_DEPTH > 1) ? $clog2(FIN_DEPTH) : 1;
    localparam int NW = $clog2(FIN_DEPTH + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(MESH_WIDTH - 1);
    localparam logic [CW-1:0] MESH_CNT  = CW'(MESH_WIDTH);

    logic [SW-1:0]       step_q, step_d;
    logic                ff_valid_q, ff_valid_d;
    logic [RW-1:0]       ff_data_q, ff_data_d, ff_acc_q, ff_acc_d, ff_weight_q, ff_weight_d;
    logic [ID_WIDTH-1:0] ff_id_q, ff_id_d;
    logic [CW-1:0]       ff_rows_q, ff_rows_d, ff_cols_q, ff_cols_d;
    logic                fs_valid_q, fs_valid_d;
    logic [RW-1:0]       fs_acc_q, fs_acc_d;
    logic [ID_WIDTH-1:0] fs_id_q, fs_id_d;
    logic [CW-1:0]       fs_rows_q, fs_rows_d;
    logic                dr_valid_q, dr_valid_d;
    logic [RW-1:0]       dr_acc_q, dr_acc_d;
    logic [ID_WIDTH-1:0] dr_id_q, dr_id_d;
    logic [CW-1:0]       dr_rows_q, dr_rows_d;

    logic [ID_WIDTH-1:0] fin_mem_q [FIN_DEPTH];
    logic [PW-1:0]       fin_rd_q, fin_rd_d, fin_wr_q, fin_wr_d;
    logic [NW-1:0]       fin_cnt_q, fin_cnt_d;
    logic                fin_empty, fin_full, push, pop;

    logic          load, advance, wrap, ff_active, dr_active, ff_ok, dr_ok, retire_ok;
    logic [CW-1:0] step_ext;

    function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] n);
        return ((n == '0) || (n > MESH_CNT)) ? MESH_CNT : n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIN_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign step_ext  = {1'b0, step_q};
    assign ready_o   = (step_q == '0) & ~ff_valid_q;
    assign load      = start_i & ready_o;
    assign wrap      = (step_q == STEP_LAST);
    assign ff_active = ff_valid_q & (step_ext < ff_rows_q);
    assign dr_active = dr_valid_q & (step_ext < dr_rows_q);
    assign ff_ok     = ~ff_active | rd_valid_i;
    assign dr_ok     = ~dr_active | wr_ready_i;
    assign fin_empty = (fin_cnt_q == '0);
    assign fin_full  = (fin_cnt_q == NW'(FIN_DEPTH));
    // A full FIFO only blocks the step that would retire the drain slot.
    assign retire_ok = ~(dr_valid_q & wrap) | ~fin_full | finished_ack_i;
    assign advance   = (ff_valid_q | fs_valid_q | dr_valid_q) & ~load & ff_ok & dr_ok & retire_ok;
    assign push      = advance & wrap & dr_valid_q;
    assign pop       = finished_ack_i & ~fin_empty;

    always_comb begin
        step_d      = step_q;
        ff_valid_d  = ff_valid_q;
        ff_data_d   = ff_data_q;
        ff_acc_d    = ff_acc_q;
        ff_weight_d = ff_weight_q;
        ff_id_d     = ff_id_q;
        ff_rows_d   = ff_rows_q;
        ff_cols_d   = ff_cols_q;
        fs_valid_d  = fs_valid_q;
        fs_acc_d    = fs_acc_q;
        fs_id_d     = fs_id_q;
        fs_rows_d   = fs_rows_q;
        dr_valid_d  = dr_valid_q;
        dr_acc_d    = dr_acc_q;
        dr_id_d     = dr_id_q;
        dr_rows_d   = dr_rows_q;
        if (load) begin
            ff_valid_d  = 1'b1;
            ff_data_d   = data_reg_i;
            ff_acc_d    = acc_reg_i;
            ff_weight_d = weight_reg_i;
            ff_id_d     = id_i;
            ff_rows_d   = clamp_cnt(rows_i);
            ff_cols_d   = clamp_cnt(cols_i);
        end else if (advance) begin
            if (wrap) begin
                step_d     = '0;
                dr_valid_d = fs_valid_q;
                dr_acc_d   = fs_acc_q;
                dr_id_d    = fs_id_q;
                dr_rows_d  = fs_rows_q;
                fs_valid_d = ff_valid_q;
                fs_acc_d   = ff_acc_q;
                fs_id_d    = ff_id_q;
                fs_rows_d  = ff_rows_q;
                ff_valid_d = 1'b0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_comb begin
        fin_rd_d  = pop ? ptr_inc(fin_rd_q) : fin_rd_q;
        fin_wr_d  = push ? ptr_inc(fin_wr_q) : fin_wr_q;
        fin_cnt_d = fin_cnt_q + NW'(push) - NW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q      <= '0;
            ff_valid_q  <= 1'b0;
            ff_data_q   <= '0;
            ff_acc_q    <= '0;
            ff_weight_q <= '0;
            ff_id_q     <= '0;
            ff_rows_q   <= '0;
            ff_cols_q   <= '0;
            fs_valid_q  <= 1'b0;
            fs_acc_q    <= '0;
            fs_id_q     <= '0;
            fs_rows_q   <= '0;
            dr_valid_q  <= 1'b0;
            dr_acc_q    <= '0;
            dr_id_q     <= '0;
            dr_rows_q   <= '0;
            fin_rd_q    <= '0;
            fin_wr_q    <= '0;
            fin_cnt_q   <= '0;
        end else begin
            step_q      <= step_d;
            ff_valid_q  <= ff_valid_d;
            ff_data_q   <= ff_data_d;
            ff_acc_q    <= ff_acc_d;
            ff_weight_q <= ff_weight_d;
            ff_id_q     <= ff_id_d;
            ff_rows_q   <= ff_rows_d;
            ff_cols_q   <= ff_cols_d;
            fs_valid_q  <= fs_valid_d;
            fs_acc_q    <= fs_acc_d;
            fs_id_q     <= fs_id_d;
            fs_rows_q   <= fs_rows_d;
            dr_valid_q  <= dr_valid_d;
            dr_acc_q    <= dr_acc_d;
            dr_id_q     <= dr_id_d;
            dr_rows_q   <= dr_rows_d;
            fin_rd_q    <= fin_rd_d;
            fin_wr_q    <= fin_wr_d;
            fin_cnt_q   <= fin_cnt_d;
        end
    end

    // Entries are only visible through the count, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fin_mem_q[fin_wr_q] <= dr_id_q;
        end
    end

    always_comb begin
        feed_col_mask_o = '0;
        for (int c = 0; c < MESH_WIDTH; c++) begin
            feed_col_mask_o[c] = ff_valid_q & (CW'(c) < ff_cols_q);
        end
    end

    assign data_raddr_o   = ff_valid_q ? ff_data_q : '0;
    assign acc_raddr_o    = ff_valid_q ? ff_acc_q : '0;
    assign weight_raddr_o = ff_valid_q ? ff_weight_q : '0;
    assign rd_row_o       = step_q;
    assign rd_req_o       = ff_active;
    assign rd_last_o      = ff_active & (step_ext == (ff_rows_q - CW'(1)));
    assign zero_inject_o  = ~ff_active;
    assign wr_addr_o      = dr_valid_q ? dr_acc_q : '0;
    assign wr_row_o       = step_q;
    assign wr_en_o        = dr_active;
    assign wr_last_o      = dr_active & (step_ext == (dr_rows_q - CW'(1)));
    assign pump_o         = advance;
    assign sa_input_id_o  = ff_valid_q ? ff_id_q : '0;
    assign sa_output_id_o = dr_valid_q ? dr_id_q : '0;
    assign finished_o     = ~fin_empty;
    assign finished_id_o  = fin_empty ? '0 : fin_mem_q[fin_rd_q];

endmodule

// File: tb/tb_sa_pipe_ctrl.sv
// Bench for sa_pipe_ctrl: directed scenarios plus randomized traffic, every cycle
// checked against a model that tracks each instruction by pump pulses since accept.
module tb_sa_pipe_ctrl;
    localparam int M     = 4;
    localparam int DEPTH = 2;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, ready_o;
    logic [2:0] data_reg_i, acc_reg_i, weight_reg_i;
    logic [3:0] id_i;
    logic [2:0] rows_i, cols_i;
    logic [2:0] data_raddr_o, acc_raddr_o, weight_raddr_o, wr_addr_o;
    logic [1:0] rd_row_o, wr_row_o;
    logic       rd_req_o, rd_valid_i, rd_last_o, zero_inject_o;
    logic [3:0] feed_col_mask_o;
    logic       wr_en_o, wr_ready_i, wr_last_o, pump_o;
    logic [3:0] sa_input_id_o, sa_output_id_o, finished_id_o;
    logic       finished_o, finished_ack_i;

    sa_pipe_ctrl #(.MESH_WIDTH(M), .N_REGS(8), .ID_WIDTH(4), .FIN_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
        .data_reg_i(data_reg_i), .acc_reg_i(acc_reg_i), .weight_reg_i(weight_reg_i),
        .id_i(id_i), .rows_i(rows_i), .cols_i(cols_i),
        .data_raddr_o(data_raddr_o), .acc_raddr_o(acc_raddr_o), .weight_raddr_o(weight_raddr_o),
        .rd_row_o(rd_row_o), .rd_req_o(rd_req_o), .rd_valid_i(rd_valid_i), .rd_last_o(rd_last_o),
        .zero_inject_o(zero_inject_o), .feed_col_mask_o(feed_col_mask_o),
        .wr_addr_o(wr_addr_o), .wr_row_o(wr_row_o), .wr_en_o(wr_en_o), .wr_ready_i(wr_ready_i),
        .wr_last_o(wr_last_o), .pump_o(pump_o),
        .sa_input_id_o(sa_input_id_o), .sa_output_id_o(sa_output_id_o),
        .finished_o(finished_o), .finished_id_o(finished_id_o), .finished_ack_i(finished_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each instruction needs 3*M pumps after acceptance; its pump offset k selects
    // the slot (FF: k<M, FS: k<2M, DR: k<3M) and the row it touches (k mod M).
    typedef struct {
        int id, rows, cols, dreg, areg, wreg, p0;
    } ins_t;

    ins_t inf[$];
    int   fifo[$];
    int   pumps;
    int   ffi, dri, step;
    bit   e_ready, e_load, e_rd_req, e_rd_last, e_wr_en, e_wr_last, e_fin, e_retire, e_pump;
    int   e_mask, e_draddr, e_araddr, e_wraddr, e_wr_addr, e_in_id, e_out_id, e_fin_id;

    task automatic model_reset();
        inf.delete();
        fifo.delete();
        pumps = 0;
    endtask

    task automatic model_eval();
        ffi = -1;
        dri = -1;
        foreach (inf[i]) begin
            int k;
            k = pumps - inf[i].p0;
            if (k < M) ffi = i;
            else if (k >= 2 * M) dri = i;
        end
        step      = pumps % M;
        e_ready   = (step == 0) && (ffi < 0);
        e_load    = start_i && e_ready;
        e_rd_req  = (ffi >= 0) && (step < inf[ffi].rows);
        e_rd_last = e_rd_req && (step == inf[ffi].rows - 1);
        e_mask    = (ffi >= 0) ? ((1 << inf[ffi].cols) - 1) : 0;
        e_draddr  = (ffi >= 0) ? inf[ffi].dreg : 0;
        e_araddr  = (ffi >= 0) ? inf[ffi].areg : 0;
        e_wraddr  = (ffi >= 0) ? inf[ffi].wreg : 0;
        e_in_id   = (ffi >= 0) ? inf[ffi].id : 0;
        e_wr_en   = (dri >= 0) && (step < inf[dri].rows);
        e_wr_last = e_wr_en && (step == inf[dri].rows - 1);
        e_wr_addr = (dri >= 0) ? inf[dri].areg : 0;
        e_out_id  = (dri >= 0) ? inf[dri].id : 0;
        e_fin     = (fifo.size() > 0);
        e_fin_id  = e_fin ? fifo[0] : 0;
        e_retire  = (dri >= 0) && (step == M - 1);
        e_pump    = (inf.size() > 0) && !e_load && (!e_rd_req || rd_valid_i) &&
                    (!e_wr_en || wr_ready_i) &&
                    (!e_retire || (fifo.size() < DEPTH) || finished_ack_i);
    endtask

    task automatic model_update();
        int r, c;
        if (rst_i) return;
        if (e_fin && finished_ack_i) void'(fifo.pop_front());
        if (e_pump) begin
            if (e_retire) begin
                fifo.push_back(inf[dri].id);
                inf.delete(dri);
            end
            pumps++;
        end
        if (e_load) begin
            r = int'(rows_i);
            c = int'(cols_i);
            if (r == 0 || r > M) r = M;
            if (c == 0 || c > M) c = M;
            inf.push_back('{id: int'(id_i), rows: r, cols: c, dreg: int'(data_reg_i),
                            areg: int'(acc_reg_i), wreg: int'(weight_reg_i), p0: pumps});
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        model_eval();
        chk("ready", 32'(ready_o), 32'(e_ready));
        chk("rd_req", 32'(rd_req_o), 32'(e_rd_req));
        chk("rd_row", 32'(rd_row_o), 32'(step));
        chk("rd_last", 32'(rd_last_o), 32'(e_rd_last));
        chk("zero_inject", 32'(zero_inject_o), 32'(!e_rd_req));
        chk("col_mask", 32'(feed_col_mask_o), 32'(e_mask));
        chk("data_raddr", 32'(data_raddr_o), 32'(e_draddr));
        chk("acc_raddr", 32'(acc_raddr_o), 32'(e_araddr));
        chk("weight_raddr", 32'(weight_raddr_o), 32'(e_wraddr));
        chk("wr_en", 32'(wr_en_o), 32'(e_wr_en));
        chk("wr_last", 32'(wr_last_o), 32'(e_wr_last));
        chk("wr_row", 32'(wr_row_o), 32'(step));
        chk("wr_addr", 32'(wr_addr_o), 32'(e_wr_addr));
        chk("pump", 32'(pump_o), 32'(e_pump));
        chk("in_id", 32'(sa_input_id_o), 32'(e_in_id));
        chk("out_id", 32'(sa_output_id_o), 32'(e_out_id));
        chk("finished", 32'(finished_o), 32'(e_fin));
        chk("finished_id", 32'(finished_id_o), 32'(e_fin_id));
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        start_i = 1'b0; finished_ack_i = 1'b0; rd_valid_i = 1'b1; wr_ready_i = 1'b1;
        rst_i = 1'b1;
        model_reset();
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic set_instr(input int id, input int rows, input int cols);
        id_i = 4'(id); rows_i = 3'(rows); cols_i = 3'(cols);
        data_reg_i = 3'(id + 1); acc_reg_i = 3'(id + 2); weight_reg_i = 3'(id + 3);
    endtask

    initial begin
        int n, first, pops;
        int acc_cyc [3];
        set_instr(0, 4, 4);
        do_reset();

        // single full-size instruction
        set_instr(5, 4, 4);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            chk("t1_rd_req", 32'(rd_req_o), 32'(c >= 1 && c <= 4));
            if (c <= 4) chk("t1_rd_row", 32'(rd_row_o), 32'(c - 1));
            chk("t1_rd_last", 32'(rd_last_o), 32'(c == 4));
            chk("t1_wr_en", 32'(wr_en_o), 32'(c >= 9 && c <= 12));
            chk("t1_finished", 32'(finished_o), 32'(c >= 13));
            if (c == 13) chk("t1_finished_id", 32'(finished_id_o), 32'd5);
            if (c == 5) chk("t1_ready", 32'(ready_o), 32'd1);
            cycle();
        end
        finished_ack_i = 1'b1;
        cycle();
        finished_ack_i = 1'b0;

        // partial tile 2x3
        do_reset();
        set_instr(6, 2, 3);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (c <= 4) begin
                chk("t2_rd_req", 32'(rd_req_o), 32'(c <= 2));
                chk("t2_zero", 32'(zero_inject_o), 32'(c > 2));
                chk("t2_mask", 32'(feed_col_mask_o), 32'h7);
            end
            chk("t2_wr_en", 32'(wr_en_o), 32'(c >= 9 && c <= 10));
            chk("t2_wr_last", 32'(wr_last_o), 32'(c == 10));
            cycle();
        end
        finished_ack_i = 1'b1;
        cycle();
        finished_ack_i = 1'b0;

        // back-to-back IDs 1,2,3
        do_reset();
        n = 0; first = -1; pops = 0;
        for (int c = 0; c < 60; c++) begin
            start_i = (n < 3);
            set_instr(n + 1, 4, 4);
            finished_ack_i = 1'b0;
            #1;
            if (start_i && ready_o) begin
                acc_cyc[n] = c;
                n++;
            end
            if (finished_o === 1'b1) begin
                if (first < 0) first = c;
                chk("t3_pop_order", 32'(finished_id_o), 32'(pops + 1));
                finished_ack_i = 1'b1;
                pops++;
            end
            cycle();
        end
        start_i = 1'b0; finished_ack_i = 1'b0;
        chk("t3_accepted", 32'(n), 32'd3);
        chk("t3_acc0", 32'(acc_cyc[0]), 32'd0);
        chk("t3_acc1", 32'(acc_cyc[1]), 32'd5);
        chk("t3_acc2", 32'(acc_cyc[2]), 32'd10);
        chk("t3_first_fin", 32'(first), 32'd15);
        chk("t3_pops", 32'(pops), 32'd3);

        // write-side stall at DR step 1
        do_reset();
        set_instr(7, 4, 4);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 9; c++) cycle();
        for (int s = 0; s < 3; s++) begin
            wr_ready_i = 1'b0;
            rd_valid_i = 1'($urandom_range(0, 1));
            #1;
            chk("t4_stall_pump", 32'(pump_o), 32'd0);
            chk("t4_stall_row", 32'(wr_row_o), 32'd1);
            chk("t4_stall_wr_en", 32'(wr_en_o), 32'd1);
            cycle();
        end
        wr_ready_i = 1'b1; rd_valid_i = 1'b1;
        #1;
        chk("t4_resume_pump", 32'(pump_o), 32'd1);
        chk("t4_resume_row", 32'(wr_row_o), 32'd1);
        finished_ack_i = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        finished_ack_i = 1'b0;

        // finished FIFO back-pressure
        do_reset();
        n = 0;
        for (int c = 0; c < 60; c++) begin
            start_i = (n < 4);
            set_instr(n + 1, 4, 4);
            #1;
            if (start_i && ready_o) n++;
            cycle();
        end
        start_i = 1'b0;
        #1;
        chk("t5_blocked_pump", 32'(pump_o), 32'd0);
        chk("t5_head", 32'(finished_id_o), 32'd1);
        finished_ack_i = 1'b1;
        #1;
        chk("t5_release_pump", 32'(pump_o), 32'd1);
        for (int c = 0; c < 60; c++) cycle();
        finished_ack_i = 1'b0;

        // reset in the middle of a drain
        do_reset();
        n = 0;
        for (int c = 0; c < 15; c++) begin
            start_i = (n < 2);
            set_instr(n + 1, 4, 4);
            #1;
            if (start_i && ready_o) n++;
            cycle();
        end
        start_i = 1'b0;
        #1;
        chk("t6_pre_finished", 32'(finished_o), 32'd1);
        chk("t6_pre_wr_en", 32'(wr_en_o), 32'd1);
        do_reset();
        #1;
        chk("t6_finished", 32'(finished_o), 32'd0);
        chk("t6_ready", 32'(ready_o), 32'd1);
        chk("t6_pump", 32'(pump_o), 32'd0);
        set_instr(9, 4, 4);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) cycle();
        #1;
        chk("t6_fresh_finished", 32'(finished_o), 32'd1);
        chk("t6_fresh_id", 32'(finished_id_o), 32'd9);
        finished_ack_i = 1'b1;
        cycle();
        finished_ack_i = 1'b0;

        // randomized traffic with stalls, odd sizes and sporadic acks
        do_reset();
        for (int c = 0; c < 800; c++) begin
            start_i        = ($urandom_range(0, 2) != 0);
            id_i           = 4'($urandom_range(0, 15));
            rows_i         = 3'($urandom_range(0, 7));
            cols_i         = 3'($urandom_range(0, 7));
            data_reg_i     = 3'($urandom_range(0, 7));
            acc_reg_i      = 3'($urandom_range(0, 7));
            weight_reg_i   = 3'($urandom_range(0, 7));
            rd_valid_i     = ($urandom_range(0, 3) != 0);
            wr_ready_i     = ($urandom_range(0, 3) != 0);
            finished_ack_i = ($urandom_range(0, 3) == 0);
            cycle();
        end
        start_i = 1'b0; rd_valid_i = 1'b1; wr_ready_i = 1'b1; finished_ack_i = 1'b1;
        for (int c = 0; c < 60; c++) cycle();
        #1;
        chk("drain_finished", 32'(finished_o), 32'd0);
        chk("drain_pump", 32'(pump_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
